mul_seq: RTL and testbench

MUL_SEQ -- requirements
Module: mul_seq

---
 rtl/globals_pkg.sv | 7 +
 rtl/mul_seq.sv | 122 ++++++++++++
 tb/tb_mul_seq.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/globals_pkg.sv
// Shared project-wide constants.
// Blocks that need the machine data width take it from here.
package globals_pkg;

  localparam int DATA_SIZE = 32;

endpackage : globals_pkg

// File: rtl/mul_seq.sv
// Sequential signed multiplier using shift-and-add on the operand magnitudes.
// The loop stops early once no set bits remain in |B|.
module mul_seq
  import globals_pkg::*;
#(
  parameter int MULTIPLICAND_WIDTH = DATA_SIZE,
  parameter int MULTIPLIER_WIDTH   = DATA_SIZE
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic                                                  valid_in,
  output logic                                                  in_ready,
  input  logic signed [MULTIPLICAND_WIDTH-1:0]                  multiplicand,
  input  logic signed [MULTIPLIER_WIDTH-1:0]                    multiplier,
  output logic signed [MULTIPLICAND_WIDTH+MULTIPLIER_WIDTH-1:0] product,
  output logic                                                  valid_out,
  output logic                                                  overflow
);

  localparam int MCW = MULTIPLICAND_WIDTH;
  localparam int MW  = MULTIPLIER_WIDTH;
  localparam int PW  = MCW + MW;

  typedef enum logic [1:0] {
    IDLE,
    LOOP,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [PW-1:0]         a_q, a_d;
  logic [PW-1:0]         acc_q, acc_d;
  logic [MW-1:0]         b_q, b_d;
  logic                  sign_q, sign_d;
  logic signed [PW-1:0]  product_q, product_d;
  logic                  overflow_q, overflow_d;
  logic                  valid_q, valid_d;

  logic [MCW-1:0]        mag_a;
  logic [MW-1:0]         mag_b;
  logic [MW-1:0]         b_shift;
  logic [PW-1:0]         result;
  logic [PW-DATA_SIZE:0] upper;

  // Unsigned magnitudes, so the most negative operand keeps its full value.
  always_comb begin
    mag_a   = multiplicand[MCW-1] ? (~multiplicand + MCW'(1)) : multiplicand;
    mag_b   = multiplier[MW-1]    ? (~multiplier + MW'(1))    : multiplier;
    b_shift = b_q >> 1;
    result  = sign_q ? (~acc_q + PW'(1)) : acc_q;
    upper   = result[PW-1:DATA_SIZE-1];
  end

  always_comb begin
    // NOTE: every next-state value gets a default up front, so no path through
    // the case statement leaves one unassigned and infers a latch.
    state_d    = state_q;
    a_d        = a_q;
    acc_d      = acc_q;
    b_d        = b_q;
    sign_d     = sign_q;
    product_d  = product_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_in) begin
          a_d     = {{MW{1'b0}}, mag_a};
          b_d     = mag_b;
          sign_d  = multiplicand[MCW-1] ^ multiplier[MW-1];
          acc_d   = '0;
          state_d = (mag_a == '0 || mag_b == '0) ? DONE : LOOP;
        end
      end
      LOOP: begin
        if (b_q[0]) acc_d = acc_q + a_q;
        a_d = a_q << 1;
        b_d = b_shift;
        if (b_shift == '0) state_d = DONE;
      end
      DONE: begin
        product_d  = result;
        // Fits the signed DATA_SIZE range only when all upper bits match the sign.
        overflow_d = !((&upper) || (~|upper));
        valid_d    = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      a_q        <= '0;
      acc_q      <= '0;
      b_q        <= '0;
      sign_q     <= 1'b0;
      product_q  <= '0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every register update from the
      // values held before the edge, independent of statement order.
      state_q    <= state_d;
      a_q        <= a_d;
      acc_q      <= acc_d;
      b_q        <= b_d;
      sign_q     <= sign_d;
      product_q  <= product_d;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign product   = product_q;
  assign overflow  = overflow_q;
  assign valid_out = valid_q;

endmodule : mul_seq

// File: tb/tb_mul_seq.sv
// Scoreboard bench for mul_seq: the driver queues the expected result and latency
// of each accepted operation, and the monitor checks every valid_out pulse.
module tb_mul_seq;

  logic               clk;
  logic               reset;
  logic               valid_in;
  logic               in_ready;
  logic signed [31:0] multiplicand;
  logic signed [31:0] multiplier;
  logic signed [63:0] product;
  logic               valid_out;
  logic               overflow;

  typedef struct {
    longint p;
    logic   ovf;
    int     acc_cyc;
    int     lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic prev_vo  = 1'b0;

  mul_seq dut (
    .clk         (clk),
    .reset       (reset),
    .valid_in    (valid_in),
    .in_ready    (in_ready),
    .multiplicand(multiplicand),
    .multiplier  (multiplier),
    .product     (product),
    .valid_out   (valid_out),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: pops one expectation per valid_out pulse.
  always @(negedge clk) begin
    if (!reset) begin
      if (valid_out) begin
        check("valid_out_single_cycle", longint'(prev_vo), 0);
        if (sb.size() == 0) begin
          check("unexpected_valid_out", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("product", product, e.p);
          check("overflow", longint'(overflow), longint'(e.ovf));
          check("latency", cyc - e.acc_cyc, e.lat);
        end
      end
      prev_vo = valid_out;
    end else begin
      prev_vo = 1'b0;
    end
  end

  function automatic longint model_p(input int a, input int b);
    return longint'(a) * longint'(b);
  endfunction

  function automatic logic model_ovf(input longint p);
    return (p < -64'sd2147483648) || (p > 64'sd2147483647);
  endfunction

  function automatic int model_lat(input int a, input int b);
    longint mag;
    int     k;
    if (a == 0 || b == 0) return 1;
    mag = (b < 0) ? -longint'(b) : longint'(b);
    k = 0;
    while (mag != 0) begin
      k++;
      mag = mag >> 1;
    end
    return k + 1;
  endfunction

  task automatic wait_ready();
    int t;
    t = 0;
    @(negedge clk);
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("in_ready_timeout", 0, 1);
  endtask

  // Directed issue: expected values are supplied by the caller.
  task automatic issue(input logic signed [31:0] a, input logic signed [31:0] b,
                       input longint exp_p, input logic exp_ovf, input int exp_lat);
    exp_t e;
    wait_ready();
    multiplicand = a;
    multiplier   = b;
    valid_in     = 1'b1;
    @(posedge clk);
    #1;
    e.p = exp_p; e.ovf = exp_ovf; e.acc_cyc = cyc; e.lat = exp_lat;
    sb.push_back(e);
    valid_in     = 1'b0;
    // Scramble operands: results must depend only on the accepted pair.
    multiplicand = ~a;
    multiplier   = 32'h5555_5555;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (sb.size() != 0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    check("drain_queue_empty", sb.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int   ha[8];
    int   hb[8];
    logic ready_now;
    logic prev_acc;

    ha = '{3, -4, 0, 12, 1, -1, 100, 7};
    hb = '{5, 7, 9, -12, 1, -1, 3, 0};

    reset        = 1'b0;
    valid_in     = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    #1 reset = 1'b1;
    @(negedge clk);
    check("reset_in_ready", longint'(in_ready), 1);
    check("reset_valid_out", longint'(valid_out), 0);
    check("reset_product", product, 0);
    check("reset_overflow", longint'(overflow), 0);
    @(negedge clk);
    reset = 1'b0;

    issue(32'sd7, -32'sd3, -64'sd21, 1'b0, 3);
    issue(32'sh8000_0000, 32'sh8000_0000, 64'sh4000_0000_0000_0000, 1'b1, 33);
    issue(32'sd0, 32'sd12345, 64'sd0, 1'b0, 1);
    issue(32'sd65536, 32'sd32768, 64'sd2147483648, 1'b1, 17);
    issue(-32'sd65536, 32'sd32768, -64'sd2147483648, 1'b0, 17);
    issue(32'sd12345, 32'sd0, 64'sd0, 1'b0, 1);
    issue(-32'sd1, -32'sd1, 64'sd1, 1'b0, 2);
    issue(32'sd2147483647, 32'sd1, 64'sd2147483647, 1'b0, 2);
    issue(32'sh8000_0000, 32'sd1, -64'sd2147483648, 1'b0, 2);
    issue(32'sh8000_0000, -32'sd1, 64'sd2147483648, 1'b1, 2);
    issue(32'sd3, 32'sd2147483647, 64'sd6442450941, 1'b1, 32);
    drain();

    // valid_in held high with operands changing every cycle.
    prev_acc = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      multiplicand = ha[c % 8];
      multiplier   = hb[c % 8];
      valid_in     = 1'b1;
      ready_now    = in_ready;
      if (prev_acc) check("busy_in_ready_low", longint'(in_ready), 0);
      @(posedge clk);
      #1;
      if (ready_now) begin
        exp_t e;
        e.p       = model_p(ha[c % 8], hb[c % 8]);
        e.ovf     = model_ovf(e.p);
        e.acc_cyc = cyc;
        e.lat     = model_lat(ha[c % 8], hb[c % 8]);
        sb.push_back(e);
      end
      prev_acc = ready_now;
    end
    valid_in = 1'b0;
    drain();

    // Reset in the middle of a long operation aborts it silently.
    wait_ready();
    multiplicand = 32'sd100;
    multiplier   = 32'sd255;
    valid_in     = 1'b1;
    @(posedge clk);
    #1 valid_in = 1'b0;
    repeat (3) @(negedge clk);
    check("mid_op_busy", longint'(in_ready), 0);
    reset = 1'b1;
    @(negedge clk);
    check("abort_product", product, 0);
    check("abort_overflow", longint'(overflow), 0);
    check("abort_valid_out", longint'(valid_out), 0);
    check("abort_in_ready", longint'(in_ready), 1);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    issue(32'sd5, 32'sd6, 64'sd30, 1'b0, 4);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule : tb_mul_seq
